// File: rtl/axis_sync_fifo_pkt.sv
// Single-clock AXI-Stream FIFO with a registered output stage, optional
// store-and-forward packet commit and optional drop-on-overflow.
`timescale 1ns/1ps
module axis_sync_fifo_pkt #(
  parameter int unsigned DSIZE          = 32,
  parameter int unsigned KSIZE          = DSIZE / 8,
  parameter int unsigned ASIZE          = 4,
  parameter bit          PACKET_MODE    = 1'b0,
  parameter bit          DROP_WHEN_FULL = 1'b0,
  parameter int unsigned AFULL_LEVEL    = 12
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             rx_axis_tvalid,
  output logic             rx_axis_tready,
  input  logic [DSIZE-1:0] rx_axis_tdata,
  input  logic [KSIZE-1:0] rx_axis_tkeep,
  input  logic             rx_axis_tlast,
  input  logic             tx_axis_tready,
  output logic             tx_axis_tvalid,
  output logic [DSIZE-1:0] tx_axis_tdata,
  output logic [KSIZE-1:0] tx_axis_tkeep,
  output logic             tx_axis_tlast,
  output logic [ASIZE:0]   level,
  output logic             almost_full,
  output logic             drop
);

  localparam int unsigned Depth  = 1 << ASIZE;
  localparam int unsigned EntryW = DSIZE + KSIZE + 1;

  typedef logic [ASIZE:0] ptr_t;
  localparam ptr_t PtrOne   = ptr_t'(1);
  localparam ptr_t DepthLvl = ptr_t'(Depth);
  localparam ptr_t AfullLvl = ptr_t'(AFULL_LEVEL);

  typedef enum logic {StPass, StDrop} wr_state_e;

  wr_state_e         state_q, state_d;
  ptr_t              wptr_q, wptr_d, cptr_q, cptr_d, rptr_q, rptr_d;
  logic              en_q;
  logic              drop_q, drop_d;
  logic              tvalid_q, tvalid_d;
  logic              wr_en, full, readable, load;
  logic [EntryW-1:0] out_q;
  logic [EntryW-1:0] mem_q [Depth];

  assign full     = (wptr_q - rptr_q) == DepthLvl;
  assign readable = rptr_q != cptr_q;

  // Write side: the commit pointer marks how far the reader may go.
  always_comb begin
    state_d        = state_q;
    wptr_d         = wptr_q;
    cptr_d         = cptr_q;
    drop_d         = 1'b0;
    wr_en          = 1'b0;
    rx_axis_tready = 1'b0;
    if (en_q) begin
      unique case (state_q)
        StPass: begin
          if (!full) begin
            rx_axis_tready = 1'b1;
            if (rx_axis_tvalid) begin
              wr_en  = 1'b1;
              wptr_d = wptr_q + PtrOne;
              if (!PACKET_MODE || rx_axis_tlast) cptr_d = wptr_q + PtrOne;
            end
          end else if (DROP_WHEN_FULL) begin
            // Overflow: rewind to the last committed packet and swallow the rest.
            rx_axis_tready = 1'b1;
            if (rx_axis_tvalid) begin
              wptr_d = cptr_q;
              if (rx_axis_tlast) drop_d = 1'b1;
              else               state_d = StDrop;
            end
          end
        end
        StDrop: begin
          rx_axis_tready = 1'b1;
          if (rx_axis_tvalid && rx_axis_tlast) begin
            drop_d  = 1'b1;
            state_d = StPass;
          end
        end
      endcase
    end
  end

  // Read side: refill the output register whenever it is empty or being consumed.
  always_comb begin
    load     = readable && (!tvalid_q || tx_axis_tready);
    rptr_d   = load ? rptr_q + PtrOne : rptr_q;
    tvalid_d = load || (tvalid_q && !tx_axis_tready);
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wptr_q[ASIZE-1:0]] <= {rx_axis_tlast, rx_axis_tkeep, rx_axis_tdata};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      en_q     <= 1'b0;
      state_q  <= StPass;
      wptr_q   <= '0;
      cptr_q   <= '0;
      rptr_q   <= '0;
      drop_q   <= 1'b0;
      tvalid_q <= 1'b0;
      out_q    <= '0;
    end else begin
      en_q     <= 1'b1;
      state_q  <= state_d;
      wptr_q   <= wptr_d;
      cptr_q   <= cptr_d;
      rptr_q   <= rptr_d;
      drop_q   <= drop_d;
      tvalid_q <= tvalid_d;
      if (load) out_q <= mem_q[rptr_q[ASIZE-1:0]];
    end
  end

  assign tx_axis_tvalid = tvalid_q;
  assign tx_axis_tlast  = out_q[EntryW-1];
  assign tx_axis_tkeep  = out_q[DSIZE +: KSIZE];
  assign tx_axis_tdata  = out_q[DSIZE-1:0];
  assign level          = wptr_q - rptr_q;
  assign almost_full    = level >= AfullLvl;
  assign drop           = drop_q;

endmodule

// File: tb/tb_axis_sync_fifo_pkt.sv
// Bench for axis_sync_fifo_pkt: one stream-mode instance and one packet+drop instance,
// checked against queue/count models of the FIFO's behaviour.
`timescale 1ns/1ps
module tb_axis_sync_fifo_pkt;
  localparam int unsigned Depth = 16;
  typedef logic [36:0] beat_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        s_rx_valid = 0, s_rx_ready, s_rx_last = 0, s_tx_ready = 0;
  logic [31:0] s_rx_data = 0, s_tx_data;
  logic [3:0]  s_rx_keep = 4'hF, s_tx_keep;
  logic        s_tx_valid, s_tx_last, s_afull, s_drop;
  logic [4:0]  s_level;
  logic        p_rx_valid = 0, p_rx_ready, p_rx_last = 0, p_tx_ready = 0;
  logic [31:0] p_rx_data = 0, p_tx_data;
  logic [3:0]  p_rx_keep = 4'hF, p_tx_keep;
  logic        p_tx_valid, p_tx_last, p_afull, p_drop;
  logic [4:0]  p_level;

  axis_sync_fifo_pkt #(.DSIZE(32), .KSIZE(4), .ASIZE(4), .PACKET_MODE(1'b0),
                       .DROP_WHEN_FULL(1'b0), .AFULL_LEVEL(12)) u_stream (
    .clk(clk), .rst_n(rst_n),
    .rx_axis_tvalid(s_rx_valid), .rx_axis_tready(s_rx_ready), .rx_axis_tdata(s_rx_data),
    .rx_axis_tkeep(s_rx_keep), .rx_axis_tlast(s_rx_last),
    .tx_axis_tready(s_tx_ready), .tx_axis_tvalid(s_tx_valid), .tx_axis_tdata(s_tx_data),
    .tx_axis_tkeep(s_tx_keep), .tx_axis_tlast(s_tx_last),
    .level(s_level), .almost_full(s_afull), .drop(s_drop)
  );

  axis_sync_fifo_pkt #(.DSIZE(32), .KSIZE(4), .ASIZE(4), .PACKET_MODE(1'b1),
                       .DROP_WHEN_FULL(1'b1), .AFULL_LEVEL(12)) u_pkt (
    .clk(clk), .rst_n(rst_n),
    .rx_axis_tvalid(p_rx_valid), .rx_axis_tready(p_rx_ready), .rx_axis_tdata(p_rx_data),
    .rx_axis_tkeep(p_rx_keep), .rx_axis_tlast(p_rx_last),
    .tx_axis_tready(p_tx_ready), .tx_axis_tvalid(p_tx_valid), .tx_axis_tdata(p_tx_data),
    .tx_axis_tkeep(p_tx_keep), .tx_axis_tlast(p_tx_last),
    .level(p_level), .almost_full(p_afull), .drop(p_drop)
  );

  int    n_cmp = 0;
  int    n_bad = 0;
  int    p_drops = 0;
  beat_t s_acc[$], s_got[$], p_got[$];

  // Collectors only: record handshakes seen mid-cycle.
  always @(negedge clk) begin
    if (rst_n) begin
      if (s_rx_valid && s_rx_ready) s_acc.push_back({s_rx_last, s_rx_keep, s_rx_data});
      if (s_tx_valid && s_tx_ready) s_got.push_back({s_tx_last, s_tx_keep, s_tx_data});
      if (p_tx_valid && p_tx_ready) p_got.push_back({p_tx_last, p_tx_keep, p_tx_data});
      if (p_drop) p_drops++;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  task automatic p_send(input logic [31:0] d, input logic [3:0] k, input logic l);
    p_rx_valid = 1'b1; p_rx_data = d; p_rx_keep = k; p_rx_last = l;
    @(posedge clk); #1;
    p_rx_valid = 1'b0; p_rx_last = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    #2;
    n_cmp++;
    if ({s_tx_valid, s_tx_data, s_tx_keep, s_tx_last, s_level, s_afull, s_drop, s_rx_ready} !== '0)
    begin
      n_bad++; $display("FAIL reset_stream_outputs got v=%b d=%h l=%0d rdy=%b want all 0",
                        s_tx_valid, s_tx_data, s_level, s_rx_ready);
    end
    n_cmp++;
    if ({p_tx_valid, p_tx_data, p_tx_keep, p_tx_last, p_level, p_afull, p_drop, p_rx_ready} !== '0)
    begin
      n_bad++; $display("FAIL reset_pkt_outputs got v=%b d=%h l=%0d rdy=%b want all 0",
                        p_tx_valid, p_tx_data, p_level, p_rx_ready);
    end
    repeat (2) @(posedge clk);
    @(negedge clk); rst_n = 1'b1;
    #1;
    n_cmp++;
    if ({s_rx_ready, p_rx_ready} !== 2'b00) begin
      n_bad++; $display("FAIL reset_ready_before_edge got %b%b want 00", s_rx_ready, p_rx_ready);
    end
    @(posedge clk); #1;
    n_cmp++;
    if ({s_rx_ready, p_rx_ready} !== 2'b11) begin
      n_bad++; $display("FAIL reset_ready_after_edge got %b%b want 11", s_rx_ready, p_rx_ready);
    end
  endtask

  task automatic test_stream_order;
    logic exp_v;
    s_tx_ready = 1'b1; s_rx_valid = 1'b1; s_rx_data = 0;
    for (int k = 0; k < 22; k++) begin
      @(posedge clk); #1;
      if (k + 1 < 20) s_rx_data = 32'(k + 1);
      else            s_rx_valid = 1'b0;
      exp_v = (k >= 1 && k <= 20);
      n_cmp++;
      if (s_tx_valid !== exp_v) begin
        n_bad++; $display("FAIL stream_order_valid k=%0d got %b want %b", k, s_tx_valid, exp_v);
      end
      if (exp_v) begin
        n_cmp++;
        if (s_tx_data !== 32'(k - 1)) begin
          n_bad++; $display("FAIL stream_order_data k=%0d got %0d want %0d", k, s_tx_data, k - 1);
        end
      end
      n_cmp++;
      if (s_level !== ((k <= 19) ? 5'd1 : 5'd0)) begin
        n_bad++; $display("FAIL stream_order_level k=%0d got %0d", k, s_level);
      end
    end
  endtask

  task automatic test_stream_full;
    int m, o, ld, acc_n;
    logic rdy;
    m = 0; o = 0; acc_n = 0;
    s_got.delete();
    s_tx_ready = 1'b0; s_rx_valid = 1'b1; s_rx_data = 100;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      rdy = (m < Depth);
      n_cmp++;
      if (s_rx_ready !== rdy) begin
        n_bad++; $display("FAIL full_ready k=%0d got %b want %b", k, s_rx_ready, rdy);
      end
      n_cmp++;
      if (s_level !== 5'(m)) begin
        n_bad++; $display("FAIL full_level k=%0d got %0d want %0d", k, s_level, m);
      end
      n_cmp++;
      if (s_afull !== (m >= 12)) begin
        n_bad++; $display("FAIL full_afull k=%0d got %b want %b", k, s_afull, m >= 12);
      end
      n_cmp++;
      if (s_tx_valid !== (o != 0)) begin
        n_bad++; $display("FAIL full_tvalid k=%0d got %b want %b", k, s_tx_valid, o != 0);
      end
      @(posedge clk);
      ld = (m > 0 && o == 0) ? 1 : 0;
      m = m - ld + (rdy ? 1 : 0);
      o = o | ld;
      #1;
      if (rdy) begin acc_n++; s_rx_data = 32'(100 + acc_n); end
    end
    s_rx_valid = 1'b0; s_tx_ready = 1'b1;
    for (int t = 0; t < 60 && s_got.size() < acc_n; t++) @(posedge clk);
    #1;
    n_cmp++;
    if (s_got.size() != acc_n || acc_n != 17) begin
      n_bad++; $display("FAIL full_drain_count got %0d want 17", s_got.size());
    end
    for (int i = 0; i < s_got.size(); i++) begin
      n_cmp++;
      if (s_got[i][31:0] !== 32'(100 + i)) begin
        n_bad++; $display("FAIL full_drain_data i=%0d got %0d want %0d", i, s_got[i][31:0], 100 + i);
      end
    end
  endtask

  task automatic test_back_to_back;
    beat_t exp[$];
    s_got.delete();
    s_tx_ready = 1'b0; s_rx_valid = 1'b1; s_rx_keep = 4'hF; s_rx_last = 1'b0;
    for (int i = 0; i < 59; i++) begin
      if (i == 9) begin
        n_cmp++;
        if (s_level !== 5'd8) begin
          n_bad++; $display("FAIL b2b_prefill_level got %0d want 8", s_level);
        end
        s_tx_ready = 1'b1;
      end
      s_rx_data = $urandom;
      exp.push_back({1'b0, 4'hF, s_rx_data});
      @(posedge clk); #1;
      if (i >= 9) begin
        n_cmp++;
        if (s_level !== 5'd8) begin
          n_bad++; $display("FAIL b2b_level i=%0d got %0d want 8", i, s_level);
        end
      end
    end
    s_rx_valid = 1'b0;
    for (int t = 0; t < 60 && s_got.size() < exp.size(); t++) @(posedge clk);
    #1;
    n_cmp++;
    if (s_got.size() != exp.size()) begin
      n_bad++; $display("FAIL b2b_count got %0d want %0d", s_got.size(), exp.size());
    end
    for (int i = 0; i < s_got.size() && i < exp.size(); i++) begin
      n_cmp++;
      if (s_got[i] !== exp[i]) begin
        n_bad++; $display("FAIL b2b_data i=%0d got %h want %h", i, s_got[i], exp[i]);
      end
    end
  endtask

  task automatic test_stream_random;
    s_acc.delete(); s_got.delete();
    for (int c = 0; c < 300; c++) begin
      s_rx_valid = ($urandom_range(0, 9) < 7);
      s_rx_data  = $urandom;
      s_rx_keep  = 4'($urandom_range(0, 15));
      s_rx_last  = 1'($urandom_range(0, 1));
      s_tx_ready = (c < 150) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
      @(posedge clk); #1;
    end
    s_rx_valid = 1'b0; s_tx_ready = 1'b1;
    for (int t = 0; t < 60 && s_got.size() < s_acc.size(); t++) @(posedge clk);
    #1;
    n_cmp++;
    if (s_got.size() != s_acc.size() || s_acc.size() == 0) begin
      n_bad++; $display("FAIL rand_count got %0d want %0d", s_got.size(), s_acc.size());
    end
    for (int i = 0; i < s_got.size() && i < s_acc.size(); i++) begin
      n_cmp++;
      if (s_got[i] !== s_acc[i]) begin
        n_bad++; $display("FAIL rand_data i=%0d got %h want %h", i, s_got[i], s_acc[i]);
      end
    end
    n_cmp++;
    if (s_level !== 5'd0) begin
      n_bad++; $display("FAIL rand_final_level got %0d want 0", s_level);
    end
  endtask

  task automatic test_packet_hold;
    logic [3:0] kp[4];
    beat_t      exp[4];
    kp = '{4'hF, 4'hF, 4'hF, 4'h3};
    p_tx_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      exp[i] = {(i == 3), kp[i], $urandom};
      p_send(exp[i][31:0], kp[i], i == 3);
      n_cmp++;
      if (p_tx_valid !== 1'b0) begin
        n_bad++; $display("FAIL pkt_hold_early i=%0d got valid %b want 0", i, p_tx_valid);
      end
    end
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      n_cmp++;
      if (p_tx_valid !== (i < 4)) begin
        n_bad++; $display("FAIL pkt_hold_valid i=%0d got %b want %b", i, p_tx_valid, i < 4);
      end
      if (i < 4) begin
        n_cmp++;
        if ({p_tx_last, p_tx_keep, p_tx_data} !== exp[i]) begin
          n_bad++; $display("FAIL pkt_hold_beat i=%0d got %h want %h", i,
                            {p_tx_last, p_tx_keep, p_tx_data}, exp[i]);
        end
      end
    end
  endtask

  task automatic test_packet_drop;
    int    lens[3];
    int    held, exp_level;
    logic  dropped2, is_last, exp_drop;
    beat_t exp[$];
    lens = '{10, 9, 3};
    p_got.delete(); p_drops = 0;
    p_tx_ready = 1'b0;
    // Stalled reader: first beat of packet 1 sits in the output register.
    held      = lens[0] - 1;
    dropped2  = (held + lens[1]) > Depth;
    exp_level = held + (dropped2 ? 0 : lens[1]) + lens[2];
    for (int p = 0; p < 3; p++) begin
      for (int i = 0; i < lens[p]; i++) begin
        is_last = (i == lens[p] - 1);
        if (p != 1 || !dropped2)
          exp.push_back({is_last, 4'hF, 32'((p + 1) * 4096 + i)});
        p_send(32'((p + 1) * 4096 + i), 4'hF, is_last);
        exp_drop = (p == 1) && is_last && dropped2;
        n_cmp++;
        if (p_drop !== exp_drop) begin
          n_bad++; $display("FAIL drop_pulse p=%0d i=%0d got %b want %b", p, i, p_drop, exp_drop);
        end
      end
    end
    n_cmp++;
    if (p_level !== 5'(exp_level)) begin
      n_bad++; $display("FAIL drop_level got %0d want %0d", p_level, exp_level);
    end
    n_cmp++;
    if (p_afull !== (exp_level >= 12)) begin
      n_bad++; $display("FAIL drop_afull got %b want %b", p_afull, exp_level >= 12);
    end
    p_tx_ready = 1'b1;
    for (int t = 0; t < 60 && p_got.size() < exp.size(); t++) @(posedge clk);
    repeat (3) @(posedge clk);
    #1;
    n_cmp++;
    if (p_drops != (dropped2 ? 1 : 0)) begin
      n_bad++; $display("FAIL drop_count got %0d want %0d", p_drops, dropped2 ? 1 : 0);
    end
    n_cmp++;
    if (p_got.size() != exp.size()) begin
      n_bad++; $display("FAIL drop_out_count got %0d want %0d", p_got.size(), exp.size());
    end
    for (int i = 0; i < p_got.size() && i < exp.size(); i++) begin
      n_cmp++;
      if (p_got[i] !== exp[i]) begin
        n_bad++; $display("FAIL drop_out_beat i=%0d got %h want %h", i, p_got[i], exp[i]);
      end
    end
  endtask

  task automatic test_packet_random;
    beat_t       exp[$];
    int          total, len;
    logic [31:0] d;
    logic [3:0]  k;
    p_got.delete(); p_drops = 0;
    for (int b = 0; b < 5; b++) begin
      total = 0;
      while (1) begin
        len = $urandom_range(1, 6);
        if (total + len > Depth) break;
        for (int i = 0; i < len; i++) begin
          d = $urandom;
          k = 4'($urandom_range(1, 15));
          exp.push_back({(i == len - 1), k, d});
          p_tx_ready = 1'($urandom_range(0, 1));
          p_send(d, k, i == len - 1);
        end
        total += len;
      end
      p_tx_ready = 1'b1;
      for (int t = 0; t < 60 && p_got.size() < exp.size(); t++) @(posedge clk);
      #1;
    end
    n_cmp++;
    if (p_got.size() != exp.size() || p_drops != 0) begin
      n_bad++; $display("FAIL prand_count got %0d/%0d drops want %0d/0", p_got.size(), p_drops,
                        exp.size());
    end
    for (int i = 0; i < p_got.size() && i < exp.size(); i++) begin
      n_cmp++;
      if (p_got[i] !== exp[i]) begin
        n_bad++; $display("FAIL prand_beat i=%0d got %h want %h", i, p_got[i], exp[i]);
      end
    end
  endtask

  task automatic test_reset_mid;
    beat_t exp[$];
    p_got.delete();
    p_tx_ready = 1'b0;
    for (int i = 0; i < 3; i++) p_send(32'hA0 + 32'(i), 4'hF, i == 2);
    for (int i = 0; i < 2; i++) p_send(32'hB0 + 32'(i), 4'hF, 1'b0);
    n_cmp++;
    if (p_tx_valid !== 1'b1 || p_level !== 5'd4) begin
      n_bad++; $display("FAIL rstmid_pre got v=%b l=%0d want v=1 l=4", p_tx_valid, p_level);
    end
    #1; rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({p_tx_valid, p_tx_data, p_tx_keep, p_tx_last, p_level, p_afull, p_drop, p_rx_ready} !== '0)
    begin
      n_bad++; $display("FAIL rstmid_outputs got v=%b d=%h l=%0d rdy=%b want all 0",
                        p_tx_valid, p_tx_data, p_level, p_rx_ready);
    end
    @(negedge clk); rst_n = 1'b1; p_tx_ready = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(posedge clk); #1;
      n_cmp++;
      if (p_tx_valid !== 1'b0) begin
        n_bad++; $display("FAIL rstmid_idle c=%0d got valid %b want 0", c, p_tx_valid);
      end
    end
    for (int i = 0; i < 3; i++) begin
      exp.push_back({(i == 2), 4'hF, 32'hC0 + 32'(i)});
      p_send(32'hC0 + 32'(i), 4'hF, i == 2);
    end
    for (int t = 0; t < 30 && p_got.size() < exp.size(); t++) @(posedge clk);
    repeat (4) @(posedge clk);
    #1;
    n_cmp++;
    if (p_got.size() != exp.size()) begin
      n_bad++; $display("FAIL rstmid_count got %0d want %0d", p_got.size(), exp.size());
    end
    for (int i = 0; i < p_got.size() && i < exp.size(); i++) begin
      n_cmp++;
      if (p_got[i] !== exp[i]) begin
        n_bad++; $display("FAIL rstmid_beat i=%0d got %h want %h", i, p_got[i], exp[i]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_stream_order();
    test_stream_full();
    test_back_to_back();
    test_stream_random();
    test_packet_hold();
    test_packet_drop();
    test_packet_random();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
